// File: rtl/copy_n_pkg.sv
// copy_n_pkg: shared types, bounds and helpers for the copy_n fork.
//   copy_n_state_e : fork occupancy state (EMPTY / HOLD)
//   NOutMin/NOutMax: legal range of the N_OUT branch count
//   copy_n_out_w() : output width that holds a fully shifted copy without loss
package copy_n_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      HOLD  = 1'b1
   } copy_n_state_e;

   localparam int unsigned NOutMin = 2;
   localparam int unsigned NOutMax = 8;

   // Input width plus the largest possible shift, so no bit is ever shifted out.
   function automatic int unsigned copy_n_out_w(input int unsigned width,
                                                input int unsigned shw);
      return width + (32'd1 << shw) - 32'd1;
   endfunction

endpackage

// File: rtl/copy_n_branch.sv
// copy_n_branch: one output branch of the copy_n fork.
// Owns the branch's done bit, its valid term and the left shifter that forms the copy.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   full_i       : a token is held by the fork
//   clr_i        : clear the done bit (new token accepted or token retired)
//   data_i       : held token data
//   shamt_i      : held shift amount for this branch
//   out_ready_i  : consumer ready
//   out_valid_o  : copy available and not yet taken
//   out_data_o   : zero-extended, left-shifted copy
//   done_nxt_o   : done bit including a transfer happening this cycle
module copy_n_branch
   import copy_n_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned SHW   = 2,
   parameter int unsigned OUT_W = copy_n_out_w(WIDTH, SHW)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             full_i,
   input  logic             clr_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic [SHW-1:0]   shamt_i,
   input  logic             out_ready_i,
   output logic             out_valid_o,
   output logic [OUT_W-1:0] out_data_o,
   output logic             done_nxt_o
);

   logic done_q, done_d;

   always_comb begin
      out_valid_o = full_i && !done_q;
      done_nxt_o  = done_q || (out_valid_o && out_ready_i);
      done_d      = clr_i ? 1'b0 : done_nxt_o;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q <= 1'b0;
      end else begin
         done_q <= done_d;
      end
   end

   // Headroom bits above the data absorb the shift, so the copy is never truncated.
   always_comb begin
      out_data_o = {{(OUT_W - WIDTH){1'b0}}, data_i} << shamt_i;
   end

endmodule

// File: rtl/copy_n.sv
// copy_n: registered N-way eager fork. Accepts one token on a valid/ready input and
// delivers a left-shifted copy to each of N_OUT branches; branches complete independently
// and the next token is accepted in the cycle the last outstanding branch transfers.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   in_valid_i   : input token offered
//   in_ready_o   : input token accepted when in_valid_i && in_ready_o
//   in_data_i    : input token
//   in_shamt_i   : per-branch shift amounts, branch k at [k*SHW +: SHW]
//   out_valid_o  : branch k holds an undelivered copy
//   out_ready_i  : branch k consumer ready
//   out_data_o   : branch k copy at [k*OUT_W +: OUT_W]
//   tok_cnt_o    : accepted-token counter, wraps at 16 bits (only with COPY_N_TOKCNT_EN)
// Configuration macro: COPY_N_TOKCNT_EN adds the tok_cnt_o counter.
module copy_n
   import copy_n_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned N_OUT = 2,
   parameter int unsigned SHW   = 2,
   parameter int unsigned OUT_W = copy_n_out_w(WIDTH, SHW)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [WIDTH-1:0]       in_data_i,
   input  logic [N_OUT*SHW-1:0]   in_shamt_i,
   output logic [N_OUT-1:0]       out_valid_o,
   input  logic [N_OUT-1:0]       out_ready_i,
   output logic [N_OUT*OUT_W-1:0] out_data_o
`ifdef COPY_N_TOKCNT_EN
   ,
   output logic [15:0]            tok_cnt_o
`endif
);

   if ((N_OUT < NOutMin) || (N_OUT > NOutMax)) begin : gen_n_out_check
      $error("copy_n: N_OUT out of legal range");
   end

   copy_n_state_e state_q, state_d;

   logic [WIDTH-1:0]     data_q, data_d;
   logic [N_OUT*SHW-1:0] shamt_q, shamt_d;
   logic [N_OUT-1:0]     done_nxt;
   logic                 full;
   logic                 retire;
   logic                 accept;
   logic                 clr_done;

   // Output decode. retire looks at this cycle's transfers, so out_ready_i reaches
   // in_ready_o combinationally; that is what allows back-to-back tokens.
   always_comb begin
      full       = (state_q == HOLD);
      retire     = full && (&done_nxt);
      in_ready_o = !full || retire;
      accept     = in_valid_i && in_ready_o;
      clr_done   = accept || retire;
   end

   // Next state: accept wins over retire so a same-cycle handover stays in HOLD.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         EMPTY: begin
            if (accept) state_d = HOLD;
         end
         HOLD: begin
            if (accept) begin
               state_d = HOLD;
            end else if (retire) begin
               state_d = EMPTY;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      data_d  = accept ? in_data_i  : data_q;
      shamt_d = accept ? in_shamt_i : shamt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         shamt_q <= '0;
      end else begin
         data_q  <= data_d;
         shamt_q <= shamt_d;
      end
   end

   for (genvar k = 0; k < N_OUT; k++) begin : gen_branch
      copy_n_branch #(
         .WIDTH (WIDTH),
         .SHW   (SHW),
         .OUT_W (OUT_W)
      ) u_branch (
         .clk         (clk),
         .rst_n       (rst_n),
         .full_i      (full),
         .clr_i       (clr_done),
         .data_i      (data_q),
         .shamt_i     (shamt_q[k*SHW +: SHW]),
         .out_ready_i (out_ready_i[k]),
         .out_valid_o (out_valid_o[k]),
         .out_data_o  (out_data_o[k*OUT_W +: OUT_W]),
         .done_nxt_o  (done_nxt[k])
      );
   end

`ifdef COPY_N_TOKCNT_EN
   logic [15:0] tok_cnt_q, tok_cnt_d;

   always_comb begin
      tok_cnt_d = tok_cnt_q + 16'(accept);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tok_cnt_q <= '0;
      end else begin
         tok_cnt_q <= tok_cnt_d;
      end
   end

   assign tok_cnt_o = tok_cnt_q;
`endif

endmodule

// File: doc/copy_n.md
# copy_n

Registered N-way eager fork for the fork/join datapath: accepts one token on a valid/ready input channel and delivers a copy to each of `N_OUT` output branches. Each branch completes independently, so a slow branch never blocks a fast one from taking its copy. Each copy is left-shifted by a per-branch amount captured with the token. It replaces the fixed two-way lock-step copy-then-shift pair at the head of the fork/join pipeline.

## Interface
Parameters:
- `WIDTH`, 8, input data width
- `N_OUT`, 2, number of output branches, legal range 2..8
- `SHW`, 2, per-branch shift-amount width; `MAX_SH = 2**SHW-1`
- `OUT_W`, `WIDTH+MAX_SH`, output data width (derived; never overridden)

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous active-low reset
- `in_valid` in 1: input token offered
- `in_ready` out 1: input token accepted when `in_valid && in_ready`
- `in_data` in `WIDTH`: input token
- `in_shamt` in `N_OUT*SHW`: per-branch shift amounts; slice k is `[k*SHW +: SHW]`; sampled with the token
- `out_valid` out `N_OUT`: branch k holds an undelivered copy
- `out_ready` in `N_OUT`: branch k consumer ready
- `out_data` out `N_OUT*OUT_W`: branch k copy at `[k*OUT_W +: OUT_W]`

## Operation
- State is a holding register plus `full` and a `done[N_OUT]` mask. The FSM has two states:
  - EMPTY: `full=0`.
  - HOLD: `full=1`, token held, `done` partially set.
- Branch k transfers when `out_valid[k] && out_ready[k]`, with `out_valid[k] = full && !done[k]`.
- `done_nxt = done | (out_valid & out_ready)`.
- `retire = full && (&done_nxt)`: the last outstanding branch transfers this cycle.
- `in_ready = !full || retire`. This gives a combinational path from `out_ready` to `in_ready`, which is intended.
- On accept:
  - capture `in_data` and `in_shamt`;
  - set `full=1`;
  - clear `done` to all zeros. This overrides `retire` in the same cycle.
- On `retire` without accept: go to EMPTY and clear `done`.
- Otherwise `done <= done_nxt`.
- Data rule: `out_data[k] = {MAX_SH'b0, data} << shamt[k]`. The shift zero-fills from the LSB and never truncates.
- Branches are independent: each branch receives its copy exactly once, in any order and on any cycle.
- Reset (asynchronous, any time):
  - `full=0`, `done=0`, data and shamt registers = 0;
  - so `out_valid=0`, `out_data=0`, `in_ready=1`;
  - a held token is discarded and a partially delivered token is lost.

## Timing
- Input-to-output latency is 1 cycle: a token accepted at edge n is visible on `out_valid` after edge n.
- Throughput is 1 token/cycle when all `out_ready=1` (back-to-back accept on `retire`).
- With one branch stalled, the other branches complete, and `in_ready` stays 0 until the stalled branch transfers.
- `out_valid[k]` and `out_data[k]` must stay stable while `out_valid[k]=1` and `out_ready[k]=0`.
- `in_data` and `in_shamt` are ignored unless `in_valid && in_ready`.

## Configuration
- `COPY_N_TOKCNT_EN` defined: adds output `tok_cnt` (out, 16 bits).
  - Counts accepted input tokens.
  - Wraps 0xFFFF→0x0000.
  - Reset value is 0.
- `COPY_N_TOKCNT_EN` undefined: no port, no counter; all other behaviour is identical.

## Structure
- Package `copy_n_pkg` holds:
  - the state enum `copy_n_state_e` {EMPTY, HOLD};
  - the function `copy_n_out_w(width, shw)`;
  - localparams for the `N_OUT` legal bounds.
- Sub-module `copy_n_branch`, instantiated `N_OUT` times, owns:
  - the done bit;
  - the `out_valid` term;
  - the shifter.
- The top level keeps `full`, the data/shamt registers, the `retire`/accept logic and the optional counter.

## Test plan
- Reset mid-HOLD with `N_OUT=3`, token 0x5A held and branch 0 done: assert `rst_n=0` → all `out_valid=0`, `out_data=0`, `in_ready=1`; the token is never delivered.
- Streaming: all `out_ready=1`, tokens 0x01..0x10 back-to-back, shamt=0 → one token/cycle on every branch, in order, 1-cycle latency.
- Independent stall, `N_OUT=2`: token 0xA5, `out_ready=2'b01` for 3 cycles, then 2'b10:
  - branch 0 takes 0xA5 in cycle 1 and `out_valid[0]` drops;
  - branch 1 takes it in cycle 4;
  - `in_ready` rises only in the retire cycle;
  - the next token is accepted in that same cycle.
- Shift: `WIDTH=8`, `SHW=2`, data 0xFF, shamt {3,0} → `out_data[0]=0x0FF`, `out_data[1]=0x7F8` (11-bit, no loss).
- Stability: branch 1 stalled for 5 cycles while `in_data` toggles → `out_data[1]` is unchanged and no second accept occurs.
- With `COPY_N_TOKCNT_EN`: 65537 accepted tokens → `tok_cnt=1`.
